// File: rtl/fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : fifo_if
// Description : Write/read handshake and status bundle for the byte FIFO.
//               The master side is the producer/consumer pair. The slave
//               side is the FIFO itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface fifo_if #(
  parameter int DATA_WIDTH = 8
);

  logic                  WREN;
  logic                  RDEN;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  full;
  logic                  empty;
  logic [DATA_WIDTH-1:0] data_out;

  modport master (
    output WREN,
    output RDEN,
    output data_in,
    input  full,
    input  empty,
    input  data_out
  );

  modport slave (
    input  WREN,
    input  RDEN,
    input  data_in,
    output full,
    output empty,
    output data_out
  );

endinterface
`default_nettype wire

// File: rtl/fifo.sv
`default_nettype none
// ============================================================================
// Module      : fifo
// Description : Single-clock synchronous FIFO with registered read data.
//               Flags are decoded from an occupancy counter. Reads have one
//               cycle of latency, and there is no write-to-read bypass.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8
) (
  input  logic   clk,
  input  logic   rst,
  fifo_if.slave  bus
);

  localparam int ADDR_WIDTH = $clog2(DEPTH);

  localparam logic [ADDR_WIDTH:0]   COUNT_FULL = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   COUNT_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0]   COUNT_ZERO = '0;
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(1);

  // Storage array (not reset: contents are unreachable until rewritten)
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q,  count_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;

  logic full_w;
  logic empty_w;
  logic wr_ok;
  logic rd_ok;

  // Flags come from the registered count only. They therefore reflect
  // pre-edge state, which is what gates acceptance below.
  assign full_w  = (count_q == COUNT_FULL);
  assign empty_w = (count_q == COUNT_ZERO);

  // A write while full is dropped and a read while empty is ignored.
  assign wr_ok = bus.WREN & ~full_w;
  assign rd_ok = bus.RDEN & ~empty_w;

  assign bus.full     = full_w;
  assign bus.empty    = empty_w;
  assign bus.data_out = data_out_q;

  // Next-state for pointers, occupancy and read data. Pointers wrap naturally.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    data_out_d = data_out_q;

    if (wr_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end

    if (rd_ok) begin
      rd_ptr_d   = rd_ptr_q + PTR_ONE;
      data_out_d = mem_q[rd_ptr_q];
    end

    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + COUNT_ONE;
      2'b01:   count_d = count_q - COUNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Control state register. Reset wins over any same-cycle request.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      data_out_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      data_out_q <= data_out_d;
    end
  end

  // Array write port. A write in the reset cycle is discarded.
  always_ff @(posedge clk) begin
    if (!rst && wr_ok) begin
      mem_q[wr_ptr_q] <= bus.data_in;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo
// Description : Self-checking bench for fifo. A queue-based reference model
//               produces the expected flags and read data. A separate monitor
//               compares the DUT against the expected values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 8;

  typedef struct packed {
    logic          full;
    logic          empty;
    logic [DW-1:0] dout;
  } exp_t;

  logic clk;
  logic rst;

  fifo_if #(.DATA_WIDTH(DW)) bus ();

  fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model state
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_dout;

  // Scoreboard queues
  exp_t          exp_state[$];
  logic [DW-1:0] rd_exp[$];

  int checks   = 0;
  int failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // One stimulus cycle: drive at negedge and advance the model to post-edge state
  task automatic step(input bit r, input bit we, input bit re, input logic [DW-1:0] d);
    bit   pre_full;
    bit   pre_empty;
    exp_t e;
    @(negedge clk);
    rst         = r;
    bus.WREN    = we;
    bus.RDEN    = re;
    bus.data_in = d;
    if (r) begin
      mq.delete();
      m_dout = '0;
    end else begin
      pre_full  = (mq.size() == DEPTH);
      pre_empty = (mq.size() == 0);
      if (re && !pre_empty) begin
        m_dout = mq.pop_front();
        rd_exp.push_back(m_dout);
      end
      if (we && !pre_full) begin
        mq.push_back(d);
      end
    end
    e.full  = (mq.size() == DEPTH);
    e.empty = (mq.size() == 0);
    e.dout  = m_dout;
    exp_state.push_back(e);
  endtask

  // Monitor: detect read handshakes and compare post-edge outputs
  initial begin
    bit            fire;
    exp_t          e;
    logic [DW-1:0] d;
    forever begin
      @(negedge clk);
      #1;
      fire = bus.RDEN && !bus.empty && !rst;
      @(posedge clk);
      #1;
      if (exp_state.size() > 0) begin
        e = exp_state.pop_front();
        check("full",  32'(bus.full),     32'(e.full));
        check("empty", 32'(bus.empty),    32'(e.empty));
        check("dout",  32'(bus.data_out), 32'(e.dout));
      end
      if (fire) begin
        if (rd_exp.size() == 0) begin
          check("unexpected_read", 32'(bus.data_out), 32'hFFFF_FFFF);
        end else begin
          d = rd_exp.pop_front();
          check("read_data", 32'(bus.data_out), 32'(d));
        end
      end
    end
  end

  // Watchdog
  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // Stimulus
  initial begin
    rst         = 1'b1;
    bus.WREN    = 1'b1;
    bus.RDEN    = 1'b1;
    bus.data_in = '0;
    m_dout      = '0;

    // Reset held with both requests active
    step(1, 1, 1, 8'hAA);
    step(1, 1, 1, 8'hBB);

    // Single write then read
    step(0, 1, 0, 8'h01);
    step(0, 0, 1, 8'h00);
    step(0, 0, 0, 8'h00);

    // Fill and overflow
    for (int i = 0; i < 8; i++) step(0, 1, 0, 8'(8'h02 + i));
    step(0, 1, 0, 8'h0A);

    // Drain and underflow
    for (int i = 0; i < 9; i++) step(0, 0, 1, 8'h00);
    step(0, 0, 0, 8'h00);

    // Wrap with simultaneous read/write
    for (int i = 0; i < 4; i++) step(0, 1, 0, 8'(8'h10 + i));
    for (int i = 0; i < 12; i++) step(0, 1, 1, 8'(8'h20 + i));
    for (int i = 0; i < 4; i++) step(0, 0, 1, 8'h00);

    // Simultaneous request on empty and full FIFO
    step(0, 1, 1, 8'h31);
    step(0, 0, 1, 8'h00);
    for (int i = 0; i < 8; i++) step(0, 1, 0, 8'(8'h40 + i));
    step(0, 1, 1, 8'h4F);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 8'h00);

    // Mid-operation reset
    for (int i = 0; i < 5; i++) step(0, 1, 0, 8'(8'h60 + i));
    step(1, 0, 0, 8'h00);
    step(0, 1, 0, 8'h55);
    step(0, 0, 1, 8'h00);
    step(0, 0, 0, 8'h00);

    // Randomized phases with varying write bias
    for (int p = 0; p < 3; p++) begin
      int wp;
      wp = 70 - 20 * p;
      for (int i = 0; i < 150; i++) begin
        bit r;
        bit we;
        bit re;
        r  = ($urandom_range(0, 99) == 0);
        we = ($urandom_range(0, 99) < wp);
        re = ($urandom_range(0, 99) < 50);
        step(r, we, re, 8'($urandom));
      end
    end

    // Let the monitor consume the final cycle
    step(0, 0, 0, 8'h00);
    @(posedge clk);
    #3;
    check("pending_state", 32'(exp_state.size()), 32'd0);
    check("pending_reads", 32'(rd_exp.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fifo.md
Name: fifo

Overview:
- Single-clock synchronous first-in/first-out buffer for byte-wide data.
- Sits between a producer (write side) and a consumer (read side) in the same clock domain.
- Writes are gated by WREN; reads are gated by RDEN.
- Status flags full and empty provide flow control.

Parameters:
- DATA_WIDTH, 8, width of data_in/data_out in bits.
- DEPTH, 8, number of storage entries; must be a power of two, ≥2.
- ADDR_WIDTH, log2(DEPTH) = 3, pointer width (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock; all state changes on posedge clk.
- rst  input  1  synchronous, active-high reset; sampled on posedge clk.
- WREN  input  1  write enable; request to push data_in this cycle.
- RDEN  input  1  read enable; request to pop the oldest entry this cycle.
- data_in  input  DATA_WIDTH  write data, sampled at posedge when the write is accepted.
- full  output  1  high when the FIFO holds DEPTH entries.
- empty  output  1  high when the FIFO holds 0 entries.
- data_out  output  DATA_WIDTH  registered read data.

Behaviour:
- Storage:
  - DEPTH x DATA_WIDTH register array.
  - Write pointer wr_ptr and read pointer rd_ptr, each ADDR_WIDTH bits.
  - Occupancy counter count, ADDR_WIDTH+1 bits, range 0..DEPTH.
- Reset (rst=1 at posedge):
  - wr_ptr=0, rd_ptr=0, count=0, data_out=0.
  - Array contents need not be cleared.
  - Reset has priority over WREN/RDEN in the same cycle.
  - Reset mid-operation discards all stored data; empty=1 and full=0 from the cycle after the reset edge.
- Flags:
  - Combinational decode of registered count: empty = (count==0), full = (count==DEPTH).
  - Flags are never both high.
- Write acceptance: wr_ok = WREN & ~full.
  - On posedge with wr_ok: mem[wr_ptr] <= data_in; wr_ptr increments.
  - WREN while full is ignored: no overwrite, no pointer or count change.
- Read acceptance: rd_ok = RDEN & ~empty.
  - On posedge with rd_ok: data_out <= mem[rd_ptr]; rd_ptr increments.
  - Data is therefore valid one cycle after the RDEN edge (1-cycle read latency).
  - RDEN while empty is ignored; data_out holds its previous value.
- data_out holds its value in every cycle without an accepted read.
- Wrap-around: both pointers wrap naturally from DEPTH-1 to 0 (modulo 2^ADDR_WIDTH); no special handling.
- Count update:
  - wr_ok & ~rd_ok: +1.
  - rd_ok & ~wr_ok: -1.
  - Both or neither: unchanged.
- Simultaneous WREN & RDEN:
  - Not empty and not full: both accepted; count unchanged.
  - Empty: only the write is accepted; there is no read-through of data_in.
  - Full: only the read is accepted; the write is dropped, because full is evaluated on pre-edge state.
- Flag timing:
  - An accepted write into an empty FIFO deasserts empty in the cycle after that edge.
  - The DEPTH-th outstanding write asserts full in the cycle after its edge.
  - The read that removes the last entry asserts empty in the cycle after its edge.
- Ordering: data is read out strictly in write order; no loss or duplication for accepted operations.

Test Plan:
- Reset: hold rst=1 for 2 cycles with WREN=RDEN=1 → empty=1, full=0, data_out=0; no state change.
- Single write/read: write 0x01 → empty=0 next cycle; RDEN one cycle → data_out=0x01 next cycle, empty=1.
- Fill and overflow: write 0x02..0x09 (8 writes) → full=1 after the 8th; a 9th write of 0x0A is ignored; count stays 8.
- Drain and underflow: RDEN for 9 cycles after fill → data_out sequence 0x02..0x09, empty=1 after the 8th read; the 9th read leaves data_out=0x09.
- Wrap/simultaneous: preload 4 entries, then 12 cycles of WREN=RDEN=1 with incrementing data → count stays 4, outputs in order across the pointer wrap.
- Mid-operation reset: after 5 writes assert rst for 1 cycle → empty=1, full=0; subsequent write 0x55 then read returns 0x55.
